// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared constants and lane max helper for the pooling datapath
package pool_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH     = 3;
    localparam int MAX_W      = 32;

    // Two-operand max of one lane held in the low w bits of a and b.
    // Signed lanes are compared in offset-binary form: flipping the sign bit
    // maps two's-complement order onto unsigned order.
    function automatic logic [MAX_W-1:0] max_lane(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int               w,
        input logic             is_signed
    );
        logic [MAX_W-1:0] bias;
        bias = is_signed ? (MAX_W'(1) << (w - 1)) : '0;
        return ((a ^ bias) >= (b ^ bias)) ? a : b;
    endfunction

endpackage

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - combinational per-lane max of two packed multi-channel beats
module pool_max2
    import pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = DEF_CH,
    parameter int SIGNED = 0
) (
    input  logic [CH*DATA_W-1:0] a,
    input  logic [CH*DATA_W-1:0] b,
    output logic [CH*DATA_W-1:0] y
);

    if (DATA_W > MAX_W || DATA_W < 1) begin : g_bad_data_w
        $error("pool_max2: DATA_W out of range");
    end

    // Each channel lane is compared independently
    always_comb begin
        y = '0;
        for (int k = 0; k < CH; k++) begin
            y[k*DATA_W +: DATA_W] = DATA_W'(max_lane(MAX_W'(a[k*DATA_W +: DATA_W]),
                                                     MAX_W'(b[k*DATA_W +: DATA_W]),
                                                     DATA_W, SIGNED != 0));
        end
    end

endmodule

// File: rtl/pool_stream.sv
// rtl/pool_stream.sv - streaming 2x2 stride-2 max pooling with half-row line buffer
module pool_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int CH     = DEF_CH,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int BW   = CH * DATA_W;
    localparam int CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D = (IMG_W >= 2) ? IMG_W / 2 : 1;
    localparam int LBW  = (LB_D > 1) ? $clog2(LB_D) : 1;

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
        $error("pool_stream: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
        $error("pool_stream: IMG_H must be even and >= 2");
    end

    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [BW-1:0]  hold_reg;
    logic [BW-1:0]  hmax;
    logic [BW-1:0]  vmax;
    logic [BW-1:0]  lb_rd;
    logic [BW-1:0]  linebuf [LB_D];
    logic [LBW-1:0] lb_idx;
    logic           accept;
    logic           col_last;
    logic           row_last;

    // A single-entry output register can accept whenever it is empty or draining
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_idx   = LBW'(col >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign busy     = (col != '0) | (row != '0) | out_valid;

    pool_max2 #(.DATA_W(DATA_W), .CH(CH), .SIGNED(SIGNED)) u_hmax (
        .a (hold_reg),
        .b (in_data),
        .y (hmax)
    );

    pool_max2 #(.DATA_W(DATA_W), .CH(CH), .SIGNED(SIGNED)) u_vmax (
        .a (lb_rd),
        .b (hmax),
        .y (vmax)
    );

    // Raster position counters, advancing only on accepted beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Even columns park the left pixel of each horizontal pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else if (accept && !col[0]) begin
            hold_reg <= in_data;
        end
    end

    // Even rows store the horizontal max for the odd row below; no reset needed
    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) begin
            linebuf[lb_idx] <= hmax;
        end
    end

    // Odd-row/odd-column beats load a result; otherwise the register drains on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (accept && col[0] && row[0]) begin
            out_valid <= 1'b1;
            out_data  <= vmax;
            out_last  <= row_last & col_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
